// File: rtl/rf_pkg.sv
// Shared constants for the register-file writeback path.
package rf_pkg;
   localparam int         XLEN     = 32;
   localparam int         AW       = 5;
   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam int         NREQ_MAX = 8;

   // Index width that stays legal when only one requester exists.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// Round-robin picker: first requester after ptr (wrapping) wins; en=0 masks all grants.
module rr_arbiter
   import rf_pkg::*;
#(
   parameter int N = 2
) (
   input  logic [N-1:0]          req,
   input  logic [idx_w(N)-1:0]   ptr,
   input  logic                  en,
   output logic [N-1:0]          gnt,
   output logic [idx_w(N)-1:0]   gid
);
   localparam int            PW = idx_w(N);
   localparam logic [PW:0]   NV = (PW+1)'(N);

   logic [PW:0]   sum;
   logic [PW-1:0] idx;
   logic          found;

   // ptr < N and offset <= N, so a single subtraction implements the modulo.
   always_comb begin
      gnt   = '0;
      gid   = '0;
      found = 1'b0;
      sum   = '0;
      idx   = '0;
      for (int i = 1; i <= N; i++) begin
         sum = {1'b0, ptr} + (PW+1)'(i);
         if (sum >= NV) sum = sum - NV;
         idx = sum[PW-1:0];
         if (en && !found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            gid      = idx;
         end
      end
   end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port among NREQ writeback sources through a
// round-robin grant and a one-stage registered write buffer with read bypass.
module rf_wb_arbiter #(
   parameter int NREQ = 2,
   parameter int XLEN = rf_pkg::XLEN,
   parameter int AW   = rf_pkg::AW
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          hold,
   input  logic [NREQ-1:0]               req_valid,
   input  logic [NREQ*AW-1:0]            req_addr,
   input  logic [NREQ*XLEN-1:0]          req_data,
   output logic [NREQ-1:0]               req_ready,
   input  logic [AW-1:0]                 rd_addr1,
   input  logic [AW-1:0]                 rd_addr2,
   output logic                          rf_we,
   output logic [AW-1:0]                 rf_waddr,
   output logic [XLEN-1:0]               rf_wdata,
   output logic [rf_pkg::idx_w(NREQ)-1:0] gnt_id,
   output logic                          byp1_hit,
   output logic                          byp2_hit,
   output logic [XLEN-1:0]               byp_data
);
   import rf_pkg::*;

   localparam int IDW = idx_w(NREQ);

   if (NREQ < 1 || NREQ > NREQ_MAX) begin : g_bad_nreq
      $error("rf_wb_arbiter: NREQ out of range");
   end

   logic [IDW-1:0]  ptr;
   logic [NREQ-1:0] gnt_p0;
   logic [IDW-1:0]  gid_p0;
   logic            xfer_p0;
   logic [AW-1:0]   win_addr_p0;
   logic [XLEN-1:0] win_data_p0;

   // Stage p0: arbitration and winner select (combinational).
   rr_arbiter #(.N(NREQ)) u_rr (
      .req (req_valid),
      .ptr (ptr),
      .en  (~hold),
      .gnt (gnt_p0),
      .gid (gid_p0)
   );

   assign req_ready = gnt_p0;
   assign xfer_p0   = |gnt_p0;

   always_comb begin
      win_addr_p0 = '0;
      win_data_p0 = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_p0[i]) begin
            win_addr_p0 = req_addr[i*AW +: AW];
            win_data_p0 = req_data[i*XLEN +: XLEN];
         end
      end
   end

   // Stage p1: registered write buffer driving WE3/A3/WD3.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
         gnt_id   <= '0;
         ptr      <= IDW'(NREQ - 1);
      end else if (xfer_p0) begin
         rf_we    <= (win_addr_p0 != AW'(REG_ZERO));
         rf_waddr <= win_addr_p0;
         rf_wdata <= win_data_p0;
         gnt_id   <= gid_p0;
         ptr      <= gid_p0;
      end else begin
         rf_we    <= 1'b0;
      end
   end

   assign byp1_hit = rf_we && (rd_addr1 == rf_waddr) && (rd_addr1 != AW'(REG_ZERO));
   assign byp2_hit = rf_we && (rd_addr2 == rf_waddr) && (rd_addr2 != AW'(REG_ZERO));
   assign byp_data = rf_wdata;
endmodule
